// File: rtl/config_mem_arbiter_pkg.sv
// Shared constants for the config memory read-port arbiter.
// Holds the FSM state encoding and the default BUSY timeout length.
// Optional feature macro used by the arbiter: CFG_ARB_TIMEOUT_EN.
package config_mem_arbiter_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam int DEFAULT_TIMEOUT_CYCLES = 16;

endpackage

// File: rtl/config_mem_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin winner selection.
// Ports:
//   req      in   NUM_REQ  request vector
//   ptr      in   IDX_W    index with highest priority this round (must be < NUM_REQ)
//   winner   out  IDX_W    first requesting index at or after ptr, wrapping
//   any_req  out  1        at least one request bit is set
module rr_arbiter
    import config_mem_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [IDX_W-1:0]   winner,
    output logic               any_req
);

    always_comb begin
        logic [IDX_W:0] cand;
        winner  = '0;
        any_req = 1'b0;
        cand    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            // One extra bit so ptr + offset cannot overflow before the wrap.
            cand = {1'b0, ptr} + (IDX_W + 1)'(i);
            if (cand >= (IDX_W + 1)'(NUM_REQ)) begin
                cand = cand - (IDX_W + 1)'(NUM_REQ);
            end
            if (!any_req && req[cand[IDX_W-1:0]]) begin
                winner  = cand[IDX_W-1:0];
                any_req = 1'b1;
            end
        end
    end

endmodule

// File: rtl/config_mem_arbiter.sv
// config_mem_arbiter: shares one config memory read port among NUM_REQ
// requesters, one transaction outstanding at a time, round-robin fairness.
// Optional feature macro: CFG_ARB_TIMEOUT_EN (BUSY timeout with error response).
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   req_valid_i / req_addr_i     per-requester request and packed addresses
//   rsp_ready_o                  one-hot, one-cycle response strobe
//   rsp_data_o / rsp_err_o       response data / timeout error flag
//   config_mem_addr_o            memory address (latched winner address)
//   config_mem_read_valid_o      memory read request (BUSY only)
//   config_mem_read_data_i       memory read data
//   config_mem_read_ready_i      memory data strobe (ignored outside BUSY)
//   grant_o                      current or most recent grant index
//   busy_o                       FSM not idle
//
// state | meaning
// IDLE  | no transaction; arbitrate any pending request this cycle
// BUSY  | read outstanding at config memory, waiting for read_ready
// RESP  | one-cycle response strobe to the granted requester
module config_mem_arbiter
    import config_mem_arbiter_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [NUM_REQ-1:0]          req_valid_i,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_addr_i,
    output logic [NUM_REQ-1:0]          rsp_ready_o,
    output logic [DATA_W-1:0]           rsp_data_o,
    output logic                        rsp_err_o,
    output logic [ADDR_W-1:0]           config_mem_addr_o,
    output logic                        config_mem_read_valid_o,
    input  logic [DATA_W-1:0]           config_mem_read_data_i,
    input  logic                        config_mem_read_ready_i,
    output logic [$clog2(NUM_REQ)-1:0]  grant_o,
    output logic                        busy_o
);

    localparam int IDX_W = $clog2(NUM_REQ);

    logic [1:0]        state_q;
    logic [IDX_W-1:0]  rr_ptr_q;
    logic [IDX_W-1:0]  grant_q;
    logic [IDX_W-1:0]  win_idx;
    logic              any_req;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_sel;
    logic [DATA_W-1:0] data_q;
    logic [IDX_W-1:0]  rr_ptr_next;

`ifdef CFG_ARB_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] tmo_cnt_q;
    logic             err_q;
`endif

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_arbiter (
        .req     (req_valid_i),
        .ptr     (rr_ptr_q),
        .winner  (win_idx),
        .any_req (any_req)
    );

    always_comb begin
        addr_sel = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (win_idx == IDX_W'(k)) begin
                addr_sel = req_addr_i[k*ADDR_W +: ADDR_W];
            end
        end
    end

    assign rr_ptr_next = (grant_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            rr_ptr_q <= '0;
            grant_q  <= '0;
            addr_q   <= '0;
            data_q   <= '0;
`ifdef CFG_ARB_TIMEOUT_EN
            tmo_cnt_q <= '0;
            err_q     <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (any_req) begin
                        grant_q <= win_idx;
                        addr_q  <= addr_sel;
                        state_q <= ST_BUSY;
`ifdef CFG_ARB_TIMEOUT_EN
                        // Terminal count 0 is reached on the last allowed BUSY cycle.
                        tmo_cnt_q <= TMO_W'(TIMEOUT_CYCLES - 1);
`endif
                    end
                end
                ST_BUSY: begin
                    if (config_mem_read_ready_i) begin
                        data_q  <= config_mem_read_data_i;
                        state_q <= ST_RESP;
`ifdef CFG_ARB_TIMEOUT_EN
                        err_q   <= 1'b0;
                    end else if (tmo_cnt_q == '0) begin
                        data_q  <= '0;
                        err_q   <= 1'b1;
                        state_q <= ST_RESP;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q - 1'b1;
`endif
                    end
                end
                ST_RESP: begin
                    state_q  <= ST_IDLE;
                    rr_ptr_q <= rr_ptr_next;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        rsp_ready_o = '0;
        if (state_q == ST_RESP) begin
            rsp_ready_o[grant_q] = 1'b1;
        end
    end

    assign rsp_data_o              = data_q;
    assign config_mem_addr_o       = addr_q;
    assign config_mem_read_valid_o = (state_q == ST_BUSY);
    assign busy_o                  = (state_q != ST_IDLE);
    assign grant_o                 = grant_q;

`ifdef CFG_ARB_TIMEOUT_EN
    assign rsp_err_o = (state_q == ST_RESP) && err_q;
`else
    assign rsp_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_config_mem_arbiter.sv
module tb_config_mem_arbiter;

    localparam int NUM_REQ = 2;
    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int TMO     = 16;
    localparam int IDX_W   = $clog2(NUM_REQ);

    logic                       clk_i = 1'b0;
    logic                       rst_i;
    logic [NUM_REQ-1:0]         req_valid_i;
    logic [NUM_REQ*ADDR_W-1:0]  req_addr_i;
    logic [NUM_REQ-1:0]         rsp_ready_o;
    logic [DATA_W-1:0]          rsp_data_o;
    logic                       rsp_err_o;
    logic [ADDR_W-1:0]          config_mem_addr_o;
    logic                       config_mem_read_valid_o;
    logic [DATA_W-1:0]          config_mem_read_data_i;
    logic                       config_mem_read_ready_i;
    logic [IDX_W-1:0]           grant_o;
    logic                       busy_o;

    logic [ADDR_W-1:0] req_addr_m [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_addr
        assign req_addr_i[g*ADDR_W +: ADDR_W] = req_addr_m[g];
    end

    config_mem_arbiter #(
        .NUM_REQ        (NUM_REQ),
        .ADDR_W         (ADDR_W),
        .DATA_W         (DATA_W),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk_i                   (clk_i),
        .rst_i                   (rst_i),
        .req_valid_i             (req_valid_i),
        .req_addr_i              (req_addr_i),
        .rsp_ready_o             (rsp_ready_o),
        .rsp_data_o              (rsp_data_o),
        .rsp_err_o               (rsp_err_o),
        .config_mem_addr_o       (config_mem_addr_o),
        .config_mem_read_valid_o (config_mem_read_valid_o),
        .config_mem_read_data_i  (config_mem_read_data_i),
        .config_mem_read_ready_i (config_mem_read_ready_i),
        .grant_o                 (grant_o),
        .busy_o                  (busy_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int                idx;
        logic [DATA_W-1:0] data;
        logic              err;
    } exp_t;

    exp_t exp_q[$];
    logic [DATA_W-1:0] mem_tbl [logic [ADDR_W-1:0]];

    int n_checks    = 0;
    int n_fail      = 0;
    int rsp_count   = 0;
    int model_ptr   = 0;
    int sticky_left = 0;
    int mem_delay   = -1;   // -1: random 0..3 extra BUSY cycles per transaction
    bit mem_en      = 1'b1;
    int busy_n      = 0;
    int cur_d       = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk_i);
        #1;
    endtask

    function automatic logic [DATA_W-1:0] mem_read(input logic [ADDR_W-1:0] a);
        if (mem_tbl.exists(a)) return mem_tbl[a];
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // Round-robin reference: first requester at or after p, cyclically.
    function automatic int pick(input logic [NUM_REQ-1:0] s, input int p);
        for (int i = 0; i < NUM_REQ; i++) begin
            int k;
            k = (p + i) % NUM_REQ;
            if (((s >> k) & NUM_REQ'(1)) != '0) return k;
        end
        return -1;
    endfunction

    // Queue the responses a held request set s produces: n transactions,
    // dropping each requester once served when drop is set.
    function automatic void plan(input logic [NUM_REQ-1:0] s, input int n, input bit drop);
        logic [NUM_REQ-1:0] left;
        int   k;
        exp_t e;
        left = s;
        for (int t = 0; t < n; t++) begin
            k = pick(left, model_ptr);
            if (k < 0) break;
            e.idx  = k;
            e.data = mem_read(req_addr_m[k]);
            e.err  = 1'b0;
            exp_q.push_back(e);
            model_ptr = (k + 1) % NUM_REQ;
            if (drop) left = left & ~(NUM_REQ'(1) << k);
        end
    endfunction

    task automatic wait_rsp(input int target, input int budget, input string name, output int cycles);
        cycles = 0;
        while (rsp_count < target && cycles < budget) begin
            tick();
            cycles++;
        end
        check({name, "_done"}, 64'(rsp_count >= target), 64'(1));
    endtask

    task automatic do_reset();
        rst_i       = 1'b1;
        req_valid_i = '0;
        sticky_left = 0;
        tick();
        tick();
        exp_q.delete();
        model_ptr = 0;
        rst_i     = 1'b0;
        tick();
    endtask

    // Memory model: answers a read after cur_d+1 BUSY cycles.
    initial begin
        config_mem_read_ready_i = 1'b0;
        config_mem_read_data_i  = '0;
        forever begin
            @(negedge clk_i);
            if (mem_en) begin
                config_mem_read_ready_i = 1'b0;
                if (config_mem_read_valid_o && !rst_i) begin
                    if (busy_n == 0) cur_d = (mem_delay >= 0) ? mem_delay : int'($urandom_range(0, 3));
                    busy_n++;
                    if (busy_n == cur_d + 1) begin
                        config_mem_read_ready_i = 1'b1;
                        config_mem_read_data_i  = mem_read(config_mem_addr_o);
                        busy_n = 0;
                    end
                end else begin
                    busy_n = 0;
                end
            end
        end
    end

    // Response monitor / scoreboard.
    initial begin
        forever begin
            @(negedge clk_i);
            if (!rst_i && rsp_ready_o != '0) begin
                rsp_count++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_rsp: rsp_ready=%b data=%0h with no response expected", rsp_ready_o, rsp_data_o);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("rsp_ready_onehot", 64'(rsp_ready_o), 64'(1) << e.idx);
                    check("rsp_data", 64'(rsp_data_o), 64'(e.data));
                    check("rsp_err", 64'(rsp_err_o), 64'(e.err));
                end
                if (sticky_left > 0) begin
                    sticky_left--;
                    if (sticky_left == 0) req_valid_i = '0;
                end else begin
                    req_valid_i = req_valid_i & ~rsp_ready_o;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int cyc;
        int base;
        logic [NUM_REQ-1:0] s;

        rst_i       = 1'b1;
        req_valid_i = '0;
        for (int k = 0; k < NUM_REQ; k++) req_addr_m[k] = '0;
        tick();
        tick();
        check("reset_busy", 64'(busy_o), 64'(0));
        check("reset_read_valid", 64'(config_mem_read_valid_o), 64'(0));
        check("reset_addr", 64'(config_mem_addr_o), 64'(0));
        check("reset_rsp_ready", 64'(rsp_ready_o), 64'(0));
        check("reset_rsp_data", 64'(rsp_data_o), 64'(0));
        check("reset_rsp_err", 64'(rsp_err_o), 64'(0));
        check("reset_grant", 64'(grant_o), 64'(0));
        rst_i = 1'b0;
        tick();

        // Single request, memory answers on the second BUSY cycle.
        mem_tbl.delete();
        mem_tbl[32'h4] = 32'd222;
        mem_delay     = 1;
        req_addr_m[0] = 32'h4;
        plan(2'b01, 1, 1'b1);
        base        = rsp_count;
        req_valid_i = 2'b01;
        tick();
        check("single_busy", 64'(busy_o), 64'(1));
        check("single_read_valid", 64'(config_mem_read_valid_o), 64'(1));
        check("single_mem_addr", 64'(config_mem_addr_o), 64'h4);
        check("single_grant", 64'(grant_o), 64'(0));
        wait_rsp(base + 1, 20, "single", cyc);
        check("single_latency", 64'(cyc + 1), 64'(3));
        tick();
        check("single_pulse_width", 64'(rsp_ready_o), 64'(0));
        check("single_back_idle", 64'(busy_o), 64'(0));

        // Contention from a fresh pointer: 0 then 1.
        do_reset();
        mem_tbl.delete();
        mem_tbl[32'h0] = 32'd111;
        mem_tbl[32'h4] = 32'd777;
        mem_delay     = -1;
        req_addr_m[0] = 32'h0;
        req_addr_m[1] = 32'h4;
        plan(2'b11, 2, 1'b1);
        base        = rsp_count;
        req_valid_i = 2'b11;
        wait_rsp(base + 2, 40, "contention", cyc);
        tick();
        tick();

        // Fairness: both held for four transactions, pointer back at 0.
        req_addr_m[0] = 32'h100;
        req_addr_m[1] = 32'h200;
        plan(2'b11, 4, 1'b0);
        base        = rsp_count;
        sticky_left = 4;
        req_valid_i = 2'b11;
        wait_rsp(base + 4, 80, "fairness", cyc);
        tick();
        tick();

        // Spurious memory ready while idle.
        check("spurious_pre_idle", 64'(busy_o), 64'(0));
        mem_en = 1'b0;
        config_mem_read_ready_i = 1'b1;
        config_mem_read_data_i  = 32'd999;
        tick();
        config_mem_read_ready_i = 1'b0;
        check("spurious_busy", 64'(busy_o), 64'(0));
        check("spurious_read_valid", 64'(config_mem_read_valid_o), 64'(0));
        tick();
        check("spurious_rsp_ready", 64'(rsp_ready_o), 64'(0));
        mem_en = 1'b1;

        // Reset while BUSY, late memory ready must be ignored.
        mem_delay     = 1000;
        req_addr_m[0] = 32'h8;
        base          = rsp_count;
        req_valid_i   = 2'b01;
        tick();
        tick();
        check("rstbusy_busy_before", 64'(busy_o), 64'(1));
        rst_i       = 1'b1;
        req_valid_i = '0;
        tick();
        check("rstbusy_busy", 64'(busy_o), 64'(0));
        check("rstbusy_read_valid", 64'(config_mem_read_valid_o), 64'(0));
        check("rstbusy_addr", 64'(config_mem_addr_o), 64'(0));
        check("rstbusy_grant", 64'(grant_o), 64'(0));
        rst_i = 1'b0;
        exp_q.delete();
        model_ptr = 0;
        mem_en = 1'b0;
        config_mem_read_ready_i = 1'b1;
        config_mem_read_data_i  = 32'd444;
        tick();
        config_mem_read_ready_i = 1'b0;
        tick();
        tick();
        check("rstbusy_after_busy", 64'(busy_o), 64'(0));
        check("rstbusy_after_read_valid", 64'(config_mem_read_valid_o), 64'(0));
        check("rstbusy_no_rsp", 64'(rsp_count), 64'(base));
        mem_en = 1'b1;

        // Memory never answers.
        req_addr_m[0] = 32'h10;
        base          = rsp_count;
`ifdef CFG_ARB_TIMEOUT_EN
        begin
            exp_t e;
            e.idx  = 0;
            e.data = '0;
            e.err  = 1'b1;
            exp_q.push_back(e);
            model_ptr = 1;
        end
        req_valid_i = 2'b01;
        wait_rsp(base + 1, 40, "timeout", cyc);
        check("timeout_latency", 64'(cyc), 64'(TMO + 1));
        tick();
`else
        req_valid_i = 2'b01;
        for (int i = 0; i < 40; i++) tick();
        check("no_timeout_still_busy", 64'(busy_o), 64'(1));
        check("no_timeout_no_rsp", 64'(rsp_count), 64'(base));
        do_reset();
`endif
        mem_delay = -1;

        // Randomized batches of held requests.
        for (int b = 0; b < 40; b++) begin
            s = NUM_REQ'($urandom_range(1, (1 << NUM_REQ) - 1));
            for (int k = 0; k < NUM_REQ; k++) req_addr_m[k] = ADDR_W'($urandom_range(0, 1023)) << 2;
            plan(s, NUM_REQ, 1'b1);
            req_valid_i = s;
            cyc = 0;
            while ((exp_q.size() != 0 || busy_o) && cyc < 300) begin
                tick();
                cyc++;
            end
            check("batch_drained", 64'(exp_q.size()), 64'(0));
            repeat ($urandom_range(0, 2)) tick();
        end

        check("final_queue_empty", 64'(exp_q.size()), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/config_mem_arbiter.md
CONFIG_MEM_ARBITER -- requirements
Module: config_mem_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 2: number of requesters (schedulers) sharing the config memory read port; legal range 2..8.
REQ-002 Parameter ADDR_W, default 32: config memory address width.
REQ-003 Parameter DATA_W, default 32: config memory read data width.
REQ-004 Parameter TIMEOUT_CYCLES, default 16: BUSY-cycle limit; used only when CFG_ARB_TIMEOUT_EN is defined.
REQ-005 clk_i  in  1  single clock; all state updates on its rising edge.
REQ-006 rst_i  in  1  synchronous reset, active-high.
REQ-007 req_valid_i  in  NUM_REQ  per-requester read request.
REQ-008 req_addr_i  in  NUM_REQ*ADDR_W  packed request addresses; requester k occupies bits [k*ADDR_W +: ADDR_W].
REQ-009 rsp_ready_o  out  NUM_REQ  one-hot, one-cycle response strobe to the granted requester.
REQ-010 rsp_data_o  out  DATA_W  shared response data; valid only while any rsp_ready_o bit is high.
REQ-011 rsp_err_o  out  1  response carries a timeout error; valid with rsp_ready_o.
REQ-012 config_mem_addr_o  out  ADDR_W  address to config memory.
REQ-013 config_mem_read_valid_o  out  1  read request to config memory.
REQ-014 config_mem_read_data_i  in  DATA_W  read data from config memory.
REQ-015 config_mem_read_ready_i  in  1  read data valid strobe from config memory.
REQ-016 grant_o  out  $clog2(NUM_REQ)  index of the current or most recent grant.
REQ-017 busy_o  out  1  high whenever the FSM is not in IDLE.

Function
REQ-018 The FSM SHALL have three states: IDLE, BUSY and RESP, with one memory transaction outstanding at most.
REQ-019 IDLE: when any req_valid_i bit is high, the FSM SHALL choose a winner round-robin starting at rr_ptr, latch the winner index and its address, and move to BUSY on the next edge.
REQ-020 BUSY: config_mem_read_valid_o SHALL be 1 and config_mem_addr_o SHALL equal the latched address.
REQ-021 BUSY: when config_mem_read_ready_i is 1, the FSM SHALL capture config_mem_read_data_i and move to RESP.
REQ-022 RESP: the arbiter SHALL drive rsp_ready_o[grant] high for exactly one cycle, with rsp_data_o holding the captured data. It SHALL then return to IDLE and set rr_ptr to (grant+1) mod NUM_REQ.
REQ-023 Minimum latency SHALL be 3 cycles: request seen in IDLE at cycle N, read_valid in cycles N+1.., and rsp_ready at cycle M+1 when read_ready arrives at cycle M.
REQ-024 Requesters SHALL hold req_valid_i and address until their rsp_ready_o; deasserting during BUSY SHALL NOT abort the transaction, and the response is still delivered.
REQ-025 Requests arriving while the FSM is in BUSY or RESP SHALL wait; a request still pending in IDLE is arbitrated in that same IDLE cycle.
REQ-026 config_mem_read_ready_i asserted outside BUSY SHALL be ignored.
REQ-027 Outside RESP, rsp_ready_o SHALL be 0 and rsp_err_o SHALL be 0; outside BUSY, config_mem_read_valid_o SHALL be 0.

Reset
REQ-028 While rst_i is high: state SHALL be IDLE, rr_ptr 0, grant_o 0, busy_o 0, config_mem_read_valid_o 0, config_mem_addr_o 0, rsp_ready_o 0, rsp_data_o 0, rsp_err_o 0.
REQ-029 Reset mid-transaction SHALL drop the transaction without a response; a later memory ready SHALL be ignored.

Configuration
REQ-030 With CFG_ARB_TIMEOUT_EN defined, a BUSY-cycle counter SHALL run. If config_mem_read_ready_i has not arrived after TIMEOUT_CYCLES cycles in BUSY, the FSM SHALL enter RESP with rsp_data_o=0 and rsp_err_o=1.
REQ-031 With CFG_ARB_TIMEOUT_EN undefined, no counter SHALL exist, BUSY SHALL wait indefinitely, and rsp_err_o SHALL be tied to 0.

Structure
REQ-032 The state encoding (IDLE/BUSY/RESP) and the default TIMEOUT_CYCLES constant SHALL live in the shared define include file.
REQ-033 The round-robin winner selection SHALL be one combinational sub-module, rr_arbiter (inputs: request vector and rr_ptr; outputs: winner index and any-request flag).

Verification
REQ-034 Single request: req_valid_i=01, addr0=0x4; memory ready with data 222 two cycles into BUSY -> config_mem_addr_o=0x4, then rsp_ready_o=01 for one cycle with rsp_data_o=222.
REQ-035 Contention: req_valid_i=11, addr0=0x0, addr1=0x4, data 111 then 777 -> requester 0 served first with 111, then requester 1 with 777; rr_ptr ends at 0.
REQ-036 Fairness: both requesters held active for 4 transactions -> grants alternate 0,1,0,1.
REQ-037 Spurious ready: config_mem_read_ready_i pulsed in IDLE with data 999 -> no rsp_ready_o and no state change.
REQ-038 Reset in BUSY: rst_i pulsed one cycle, then memory ready with data 444 -> no response, busy_o=0, config_mem_read_valid_o=0.
REQ-039 Timeout (CFG_ARB_TIMEOUT_EN defined, TIMEOUT_CYCLES=16): no memory ready -> after 16 BUSY cycles, rsp_ready_o=01, rsp_err_o=1, rsp_data_o=0.
